serial_gp_adder: RTL and testbench
==================================

# serial_gp_adder

Bit-serial adder that consumes the per-bit generate/propagate terms of two operands, LSB first, and resolves the carry chain one bit per clock. It is the sequential consumer of the basic generate/propagate primitives in the approximate-circuits library. It serves as an area-minimal reference adder and as the carrier for the lower-part-OR approximation. It sits between an operand source using a START pulse handshake and any block that samples the DONE-qualified result.

## Interface
- WIDTH, 8, operand and sum width; legal values are 2 to 64.
- LOWER_BITS, 2, width of the approximate lower part. It is used only when APPROX_LOWER_EN is defined. Legal values are 1 to WIDTH-1.

- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request. Sampled only in IDLE or DONE.
- A  in  WIDTH  operand A. Captured on the accepting edge.
- B  in  WIDTH  operand B. Captured on the accepting edge.
- CIN  in  1  carry-in. Captured on the accepting edge.
- BUSY  out  1  high while bits are being resolved.
- DONE  out  1  one-cycle pulse. SUM, COUT and G_VEC are valid from this cycle onward.
- SUM  out  WIDTH  registered result. Held until the next DONE.
- COUT  out  1  registered carry-out. Held until the next DONE.
- G_VEC  out  WIDTH  registered generate vector A&B. Held until the next DONE.

## Operation
- States are IDLE, RUN and DONE_ST.
- IDLE to RUN on START=1. The same edge latches A, B and CIN into the internal shift/carry registers and clears the bit index.
- In RUN, on each edge, process bit i:
  - g = a_i & b_i
  - p = a_i ^ b_i
  - s_i = p ^ c
  - c <= g | (p & c)
  - Shift s_i into the internal sum register and g into the internal generate register.
  - Increment i.
- When bit WIDTH-1 is processed, go to DONE_ST. The same edge copies the internal registers to SUM and G_VEC, and the final carry to COUT.
- DONE_ST to RUN if START=1 (back-to-back accept). Otherwise DONE_ST to IDLE.
- START in RUN is ignored. The operand registers must not change while in RUN.
- SUM, COUT and G_VEC change only on the edge that enters DONE_ST. Internal partial results are never visible on them.
- Arithmetic is modulo 2^WIDTH. The overflow bit is COUT.
- Reset:
  - RST_N low forces IDLE immediately and asynchronously, regardless of CLK.
  - SUM, COUT, G_VEC, BUSY, DONE and all internal registers go to 0.
  - A reset mid-RUN discards the operation. DONE does not pulse for it.
- Reset release: the first START is accepted on the first rising edge with RST_N high.

## Timing
- Call the accepting edge E0. Bits 0 through WIDTH-1 resolve on edges E1 through E_WIDTH.
- BUSY is 1 from after E0 until after E_WIDTH, which is exactly WIDTH cycles.
- DONE is 1 for the single cycle between E_WIDTH and E_WIDTH+1. With WIDTH=8, DONE is high 8 cycles after the accepting edge.
- Throughput is one operation per WIDTH+1 cycles. A back-to-back START held through DONE_ST gives BUSY low only in the DONE cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- The macro is APPROX_LOWER_EN.
- Not defined (exact mode): the block is an exact ripple adder, as described above.
- Defined (lower-part OR approximation):
  - For bits i < LOWER_BITS, s_i = a_i | b_i and no carry propagates.
  - The carry into bit LOWER_BITS is a[LOWER_BITS-1] & b[LOWER_BITS-1].
  - CIN is captured but ignored.
  - Upper bits use exact resolution.
- Latency, handshake and G_VEC are identical in both modes.

## Test plan
- Reset: hold RST_N=0 with CLK toggling, then assert RST_N low mid-RUN at bit 4.
  - Required: SUM=0, COUT=0, G_VEC=0, BUSY=0 and DONE=0 immediately.
  - Required: no DONE pulse for the aborted operation.
  - Required: the next START after release completes normally.
- Exact add, WIDTH=8: A=8'h5A, B=8'h3C, CIN=0.
  - Required: DONE 8 cycles after E0.
  - Required: SUM=8'h96, COUT=0, G_VEC=8'h18.
- Full carry ripple: A=8'hFF, B=8'h01, CIN=0, then A=8'hFF, B=8'h00, CIN=1.
  - Required: SUM=8'h00 and COUT=1 in both cases.
- Handshake:
  - Toggle START and change A/B every cycle during RUN. Required: a single result for the originally captured operands.
  - Hold START=1 in DONE_ST with new operands 8'h01+8'h01. Required: the second DONE exactly 9 cycles after the first, with SUM=8'h02.
- APPROX_LOWER_EN defined, LOWER_BITS=2, CIN=1:
  - A=8'h03, B=8'h01 gives SUM=8'h03, COUT=0.
  - A=8'h03, B=8'h03 gives SUM=8'h07, COUT=0.
  - A=8'hFC, B=8'h04 gives SUM=8'h00, COUT=1.

Source files
------------

// File: rtl/serial_gp_adder.sv
// serial_gp_adder: bit-serial ripple adder built from per-bit generate/propagate
// terms, resolving one bit per clock, LSB first.
// Optional feature: define APPROX_LOWER_EN to switch the lowest LOWER_BITS bits
// to a lower-part-OR approximation (no carry through the lower part, carry-in
// ignored, carry into bit LOWER_BITS taken from the top lower bit's generate).
module serial_gp_adder #(
  parameter int WIDTH      = 8,
  parameter int LOWER_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] g_vec
);

  localparam int IW = $clog2(WIDTH);

`ifdef APPROX_LOWER_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;

  state_t          state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_sh_reg;
  logic [WIDTH-1:0] g_sh_reg;
  logic             carry_reg;
  logic [IW-1:0]    idx_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic [WIDTH-1:0] g_vec_reg;

  logic a_bit, b_bit, g_bit, p_bit, s_bit, carry_next;
  logic in_lower, last_lower, last_bit, accept;

  // Per-bit generate/propagate resolution for the bit currently selected by idx_reg.
  always_comb begin
    a_bit      = a_reg[idx_reg];
    b_bit      = b_reg[idx_reg];
    g_bit      = a_bit & b_bit;
    p_bit      = a_bit ^ b_bit;
    in_lower   = APPROX && (int'(idx_reg) < LOWER_BITS);
    last_lower = (int'(idx_reg) == LOWER_BITS - 1);
    last_bit   = (idx_reg == IW'(WIDTH - 1));
    accept     = start && ((state_reg == IDLE) || (state_reg == DONE_ST));
    if (in_lower) begin
      // Lower part: OR in place of the sum, carry only leaves the top lower bit.
      s_bit      = a_bit | b_bit;
      carry_next = last_lower ? g_bit : 1'b0;
    end else begin
      s_bit      = p_bit ^ carry_reg;
      carry_next = g_bit | (p_bit & carry_reg);
    end
  end

  // Control FSM plus datapath registers; results are published only on the edge entering DONE_ST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_sh_reg <= '0;
      g_sh_reg   <= '0;
      carry_reg  <= 1'b0;
      idx_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
      g_vec_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        // Operands are frozen here for the whole RUN; START during RUN never reaches this branch.
        a_reg     <= a;
        b_reg     <= b;
        carry_reg <= cin;
        idx_reg   <= '0;
        busy_reg  <= 1'b1;
        state_reg <= RUN;
      end else begin
        case (state_reg)
          RUN: begin
            sum_sh_reg <= {s_bit, sum_sh_reg[WIDTH-1:1]};
            g_sh_reg   <= {g_bit, g_sh_reg[WIDTH-1:1]};
            carry_reg  <= carry_next;
            idx_reg    <= idx_reg + 1'b1;
            if (last_bit) begin
              sum_reg   <= {s_bit, sum_sh_reg[WIDTH-1:1]};
              g_vec_reg <= {g_bit, g_sh_reg[WIDTH-1:1]};
              cout_reg  <= carry_next;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE_ST;
            end
          end
          DONE_ST: state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign sum   = sum_reg;
  assign cout  = cout_reg;
  assign g_vec = g_vec_reg;

endmodule

// File: tb/tb_serial_gp_adder.sv
// Self-checking bench for serial_gp_adder (WIDTH=8, LOWER_BITS=2).
// Expectations follow APPROX_LOWER_EN when the bench is built with it defined.
module tb_serial_gp_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum, g_vec;

  int n_checks = 0;
  int n_fail   = 0;

  serial_gp_adder #(.WIDTH(W), .LOWER_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .g_vec(g_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic [W-1:0] exp_g;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Launch one operation from IDLE, wait (bounded) for DONE, return latency in cycles after E0.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        output int lat);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t vecs[8];
  int   lat;
  int   gap;
  int   seen_done;
  logic [W-1:0] exp_toggle_sum, exp_b2b_sum;
  logic         exp_toggle_cout;

  initial begin
`ifdef APPROX_LOWER_EN
    vecs[0] = '{8'h03, 8'h01, 1'b1, 8'h03, 1'b0, 8'h01};
    vecs[1] = '{8'h03, 8'h03, 1'b1, 8'h07, 1'b0, 8'h03};
    vecs[2] = '{8'hFC, 8'h04, 1'b1, 8'h00, 1'b1, 8'h04};
    vecs[3] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 8'h18};
    vecs[4] = '{8'hFF, 8'h01, 1'b1, 8'hFF, 1'b0, 8'h01};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h80};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 8'h01};
    exp_toggle_sum  = 8'h46;
    exp_toggle_cout = 1'b0;
    exp_b2b_sum     = 8'h01;
`else
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 8'h18};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h01};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h80};
    vecs[4] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 8'h10};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 8'h01};
    exp_toggle_sum  = 8'h47;
    exp_toggle_cout = 1'b0;
    exp_b2b_sum     = 8'h02;
`endif

    // Reset held with the clock running.
    repeat (4) @(posedge clk);
    #1;
    check("rst_sum", sum, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_g_vec", g_vec, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven operations.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      $display("op %0d: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d g=%02h lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, sum, cout, g_vec, lat);
      check("latency", lat, 8);
      check("sum", sum, vecs[i].exp_sum);
      check("cout", cout, vecs[i].exp_cout);
      check("g_vec", g_vec, vecs[i].exp_g);
      check("busy_in_done", busy, 1'b0);
      @(posedge clk); #1;
      check("done_one_cycle", done, 1'b0);
      check("sum_held", sum, vecs[i].exp_sum);
    end

    // START toggling and operands changing every cycle during RUN.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 20) begin
      start = ~start;
      a = a + 8'h11;
      b = b ^ 8'hA5;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    $display("toggle op: sum=%02h cout=%0d lat=%0d", sum, cout, lat);
    check("toggle_latency", lat, 8);
    check("toggle_sum", sum, exp_toggle_sum);
    check("toggle_cout", cout, exp_toggle_cout);
    @(posedge clk); #1;
    check("toggle_no_second_done", done, 1'b0);

    // Back-to-back: START held through DONE_ST.
    run_op(8'h5A, 8'h3C, 1'b0, lat);
    check("b2b_first_latency", lat, 8);
    check("b2b_first_sum", sum, 8'h96);
    check("b2b_busy_low_in_done", busy, 1'b0);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    gap = 0;
    @(posedge clk); #1;
    gap++;
    start = 1'b0;
    check("b2b_busy_after_reaccept", busy, 1'b1);
    while (!done && gap < 20) begin
      @(posedge clk); #1;
      gap++;
    end
    $display("b2b op: sum=%02h gap=%0d", sum, gap);
    check("b2b_gap", gap, 9);
    check("b2b_second_sum", sum, exp_b2b_sum);

    // Asynchronous reset mid-RUN, at bit 4.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum", sum, '0);
    check("async_rst_cout", cout, 1'b0);
    check("async_rst_g_vec", g_vec, '0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("aborted_no_done", seen_done, 0);
    run_op(8'h5A, 8'h3C, 1'b0, lat);
    $display("post-reset op: sum=%02h cout=%0d lat=%0d", sum, cout, lat);
    check("post_rst_latency", lat, 8);
    check("post_rst_sum", sum, 8'h96);
    check("post_rst_g_vec", g_vec, 8'h18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
